// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI command scheduler slice:
//   - sched_state_t         : scheduler FSM state encoding
//   - DEF_LENGTH_SEND_C     : default controller->peripheral word width
//   - DEF_LENGTH_RECIEVED_C : default peripheral->controller word width
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int DEF_LENGTH_SEND_C     = 8;
    localparam int DEF_LENGTH_RECIEVED_C = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_STORE,
        S_GAP
    } sched_state_t;

endpackage

// File: rtl/spi_sched_fifo.sv
// -----------------------------------------------------------------------------
// spi_sched_fifo
// Synchronous FIFO, parameterised width and depth (DEPTH power of 2, >= 2).
// Ports:
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   i_push, i_wdata : write request and data
//   i_pop           : read request (head advances)
//   o_rdata         : head entry, '0 while empty
//   o_full, o_empty : occupancy flags
//   o_count         : number of stored entries (log2(DEPTH)+1 bits)
// A push while full is accepted when a pop happens in the same cycle; a pop
// while empty is ignored, so a simultaneous push still lands.
// -----------------------------------------------------------------------------
module spi_sched_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = (r_count == '0) ? '0 : r_mem[r_rd_ptr];
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/spi_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// spi_cmd_scheduler
// Queues host words in a TX FIFO, launches one SPI transaction per word and
// stores each returned word in an RX FIFO. A transaction is only launched
// when an RX slot is free, so the RX push after spi_done can never overflow.
// Ports:
//   clk, rst                      : clock, asynchronous active-low reset
//   tx_valid/tx_ready/tx_data     : host -> TX FIFO
//   rx_valid/rx_ready/rx_data     : RX FIFO -> host (rx_data is the head)
//   data_send_c, start_comm       : word and one-cycle start pulse to SPI
//   spi_done, spi_rx_word         : completion pulse and returned word
//   busy                          : FSM not in IDLE
//   err, err_clr                  : sticky timeout flag and its clear
// Build option: define SPI_SCHED_TIMEOUT_EN to bound WAIT to TIMEOUT cycles;
// otherwise err is tied low and err_clr is ignored.
// -----------------------------------------------------------------------------
module spi_cmd_scheduler
    import spi_pkg::*;
#(
    parameter int LENGTH_SEND_C     = DEF_LENGTH_SEND_C,
    parameter int LENGTH_RECIEVED_C = DEF_LENGTH_RECIEVED_C,
    parameter int DEPTH             = 4,
    parameter int GAP               = 2,
    parameter int TIMEOUT           = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    input  logic [LENGTH_SEND_C-1:0]     tx_data,
    output logic                         rx_valid,
    input  logic                         rx_ready,
    output logic [LENGTH_RECIEVED_C-1:0] rx_data,
    output logic [LENGTH_SEND_C-1:0]     data_send_c,
    output logic                         start_comm,
    input  logic                         spi_done,
    input  logic [LENGTH_RECIEVED_C-1:0] spi_rx_word,
    output logic                         busy,
    output logic                         err,
    input  logic                         err_clr
);

    localparam int            GW         = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int            GAP_LAST_I = (GAP > 0) ? GAP - 1 : 0;
    localparam logic [GW-1:0] GAP_LAST   = GAP_LAST_I[GW-1:0];

    sched_state_t                 r_state;
    sched_state_t                 w_state_nxt;
    logic [LENGTH_SEND_C-1:0]     r_data_send;
    logic [LENGTH_RECIEVED_C-1:0] r_rx_word;
    logic [GW-1:0]                r_gap_cnt;

    logic                         w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
    logic                         w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
    logic [LENGTH_SEND_C-1:0]     w_tx_rdata;
    logic [$clog2(DEPTH):0]       w_unused_tx_count;
    logic [$clog2(DEPTH):0]       w_unused_rx_count;
    logic                         w_launch_ok;
    logic                         w_timeout;

    assign w_tx_push = tx_valid && !w_tx_full;
    assign w_rx_pop  = rx_ready && !w_rx_empty;
    // A host pop in the same cycle frees the slot this launch reserves.
    assign w_launch_ok = !w_tx_empty && (!w_rx_full || w_rx_pop);

    spi_sched_fifo #(.WIDTH(LENGTH_SEND_C), .DEPTH(DEPTH)) u_tx_fifo (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_push  (w_tx_push),
        .i_wdata (tx_data),
        .i_pop   (w_tx_pop),
        .o_rdata (w_tx_rdata),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_unused_tx_count)
    );

    spi_sched_fifo #(.WIDTH(LENGTH_RECIEVED_C), .DEPTH(DEPTH)) u_rx_fifo (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_push  (w_rx_push),
        .i_wdata (r_rx_word),
        .i_pop   (w_rx_pop),
        .o_rdata (rx_data),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_unused_rx_count)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_tx_pop    = 1'b0;
        w_rx_push   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_launch_ok) begin
                    w_tx_pop    = 1'b1;
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (spi_done)       w_state_nxt = S_STORE;
                else if (w_timeout) w_state_nxt = (GAP > 0) ? S_GAP : S_IDLE;
            end
            S_STORE: begin
                w_rx_push   = 1'b1;
                w_state_nxt = (GAP > 0) ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_data_send <= '0;
            r_rx_word   <= '0;
            r_gap_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_tx_pop) r_data_send <= w_tx_rdata;
            if ((r_state == S_WAIT) && spi_done) r_rx_word <= spi_rx_word;
            if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + 1'b1;
            else                  r_gap_cnt <= '0;
        end
    end

`ifdef SPI_SCHED_TIMEOUT_EN
    localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int            T_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [TW-1:0] T_LAST   = T_LAST_I[TW-1:0];

    logic [TW-1:0] r_wait_cnt;
    logic          r_err;

    // The slot reserved at launch is released simply by not pushing to RX.
    assign w_timeout = (r_state == S_WAIT) && !spi_done && (r_wait_cnt == T_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;
            else                   r_wait_cnt <= '0;
            if (w_timeout)    r_err <= 1'b1;
            else if (err_clr) r_err <= 1'b0;
        end
    end

    assign err = r_err;
`else
    logic w_unused_cfg;

    assign w_timeout    = 1'b0;
    assign err          = 1'b0;
    assign w_unused_cfg = err_clr | (TIMEOUT > 0);
`endif

    assign tx_ready    = !w_tx_full;
    assign rx_valid    = !w_rx_empty;
    assign data_send_c = r_data_send;
    assign start_comm  = (r_state == S_LAUNCH);
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_cmd_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_spi_cmd_scheduler
// Randomised bench for spi_cmd_scheduler with an echoing SPI peripheral model
// (returns {word, word}) and an in-order queue of expected RX words.
// -----------------------------------------------------------------------------
module tb_spi_cmd_scheduler;

    localparam int LS      = 8;
    localparam int LR      = 16;
    localparam int DEPTH   = 4;
    localparam int GAP     = 2;
    localparam int TIMEOUT = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [LS-1:0] tx_data = '0;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic [LR-1:0] rx_data;
    logic [LS-1:0] data_send_c;
    logic          start_comm;
    logic          spi_done = 1'b0;
    logic [LR-1:0] spi_rx_word = '0;
    logic          busy;
    logic          err;
    logic          err_clr = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model and SPI peripheral model state
    logic [LR-1:0] exp_q[$];
    int            n_starts   = 0;
    bit            resp_auto  = 1'b0;
    bit            resp_kick  = 1'b0;
    int            resp_lat   = 0;
    bit            resp_active = 1'b0;
    int            resp_cnt   = 0;
    logic [LS-1:0] cur_word   = '0;
    bit            prev_start = 1'b0;
    bit            have_done  = 1'b0;
    int            done_cyc   = 0;

    spi_cmd_scheduler #(
        .LENGTH_SEND_C     (LS),
        .LENGTH_RECIEVED_C (LR),
        .DEPTH             (DEPTH),
        .GAP               (GAP),
        .TIMEOUT           (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .data_send_c (data_send_c),
        .start_comm  (start_comm),
        .spi_done    (spi_done),
        .spi_rx_word (spi_rx_word),
        .busy        (busy),
        .err         (err),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Handshake monitor: every accepted TX word must come back as {w,w}, in order.
    always @(negedge clk) begin
        if (rst) begin
            if (tx_valid && tx_ready) exp_q.push_back({tx_data, tx_data});
            if (rx_valid && rx_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rx_unexpected: got %h, required no word", rx_data);
                end else if (rx_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL rx_order: got %h, required %h", rx_data, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // SPI peripheral model, sampling 2 ns after each rising edge.
    initial begin
        forever begin
            @(posedge clk); #2;
            spi_done = 1'b0;
            if (!rst) begin
                resp_active = 1'b0;
                prev_start  = 1'b0;
                have_done   = 1'b0;
            end else begin
                if (start_comm) begin
                    n_starts++;
                    checks++;
                    if (prev_start) begin
                        errors++;
                        $display("FAIL start_pulse_width: start_comm high 2 cycles, required 1");
                    end
                    if (have_done) begin
                        checks++;
                        if (cyc - done_cyc < 3 + GAP) begin
                            errors++;
                            $display("FAIL start_spacing: got %0d cycles, required >= %0d", cyc - done_cyc, 3 + GAP);
                        end
                    end
                    if (resp_auto) begin
                        resp_active = 1'b1;
                        resp_cnt    = (resp_lat > 0) ? resp_lat : int'($urandom_range(1, 8));
                        cur_word    = data_send_c;
                    end
                end else if (resp_kick) begin
                    resp_kick   = 1'b0;
                    spi_done    = 1'b1;
                    spi_rx_word = {data_send_c, data_send_c};
                    have_done   = 1'b1;
                    done_cyc    = cyc;
                end else if (resp_active) begin
                    checks++;
                    if (data_send_c !== cur_word) begin
                        errors++;
                        $display("FAIL data_hold: data_send_c=%h, required %h", data_send_c, cur_word);
                    end
                    if (resp_cnt <= 1) begin
                        spi_done    = 1'b1;
                        spi_rx_word = {cur_word, cur_word};
                        resp_active = 1'b0;
                        have_done   = 1'b1;
                        done_cyc    = cyc;
                    end else begin
                        resp_cnt--;
                    end
                end
                prev_start = start_comm;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push_word(input logic [LS-1:0] w);
        tx_data  = w;
        tx_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                @(posedge clk); #1;
                tx_valid = 1'b0;
                return;
            end
        end
        tx_valid = 1'b0;
        checks++;
        errors++;
        $display("FAIL push_timeout: tx_ready=0, required 1");
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        rx_ready = 1'b1;
        while ((exp_q.size() != 0 || busy || rx_valid) && n < 3000) begin
            step();
            n++;
        end
        rx_ready = 1'b0;
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({tx_ready, rx_valid, rx_data, data_send_c, start_comm, busy, err} !==
            {1'b1, 1'b0, {LR{1'b0}}, {LS{1'b0}}, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL %s: tx_ready=%b rx_valid=%b rx_data=%h data_send_c=%h start=%b busy=%b err=%b, required 1 0 0 0 0 0 0",
                     tag, tx_ready, rx_valid, rx_data, data_send_c, start_comm, busy, err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        check_reset_outputs("reset_held");
        rst = 1'b1;
        repeat (2) step();
        check_reset_outputs("reset_released");
    endtask

    task automatic test_single_word();
        int base;
        int n;
        resp_auto = 1'b1;
        resp_lat  = 26;
        rx_ready  = 1'b0;
        base      = n_starts;
        push_word(8'hA5);
        checks++;
        if (start_comm !== 1'b0) begin
            errors++;
            $display("FAIL single_pre_launch: start_comm=%b, required 0", start_comm);
        end
        step();
        checks++;
        if (start_comm !== 1'b1 || data_send_c !== 8'hA5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_launch: start=%b data=%h busy=%b, required 1 a5 1", start_comm, data_send_c, busy);
        end
        step();
        checks++;
        if (start_comm !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse_end: start_comm=%b, required 0", start_comm);
        end
        n = 0;
        while (!spi_done && n < 60) begin
            step();
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL single_done_wait: spi_done=0, required 1");
        end
        // spi_done has just been sampled: FSM is in STORE, RX still empty.
        checks++;
        if (rx_valid !== 1'b0 || data_send_c !== 8'hA5) begin
            errors++;
            $display("FAIL single_store: rx_valid=%b data=%h, required 0 a5", rx_valid, data_send_c);
        end
        step();
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 16'hA5A5) begin
            errors++;
            $display("FAIL single_rx: rx_valid=%b rx_data=%h, required 1 a5a5", rx_valid, rx_data);
        end
        checks++;
        if (n_starts - base !== 1) begin
            errors++;
            $display("FAIL single_starts: got %0d launches, required 1", n_starts - base);
        end
        drain();
    endtask

    task automatic test_burst();
        int base;
        resp_auto = 1'b1;
        resp_lat  = 0;
        rx_ready  = 1'b1;
        base      = n_starts;
        for (int i = 1; i <= 4; i++) push_word(LS'(i * 1));
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 6)) step();
            push_word(LS'($urandom));
        end
        drain();
        checks++;
        if (n_starts - base !== 12) begin
            errors++;
            $display("FAIL burst_starts: got %0d launches, required 12", n_starts - base);
        end
    endtask

    task automatic test_backpressure();
        int base;
        resp_auto = 1'b1;
        resp_lat  = 0;
        rx_ready  = 1'b0;
        base      = n_starts;
        for (int i = 0; i < 6; i++) push_word(LS'($urandom));
        repeat (200) step();
        checks++;
        if (n_starts - base !== DEPTH || busy !== 1'b0 || rx_valid !== 1'b1 || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: launches=%0d busy=%b rx_valid=%b tx_ready=%b, required %0d 0 1 1",
                     n_starts - base, busy, rx_valid, tx_ready, DEPTH);
        end
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        repeat (100) step();
        checks++;
        if (n_starts - base !== DEPTH + 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_one_more: launches=%0d busy=%b, required %0d 0", n_starts - base, busy, DEPTH + 1);
        end
        drain();
        checks++;
        if (n_starts - base !== 6) begin
            errors++;
            $display("FAIL bp_total: got %0d launches, required 6", n_starts - base);
        end
    endtask

    task automatic test_full_empty();
        int base;
        resp_auto = 1'b0;
        resp_lat  = 0;
        rx_ready  = 1'b0;
        base      = n_starts;
        push_word(LS'($urandom));
        repeat (4) step();
        for (int i = 0; i < DEPTH; i++) push_word(LS'($urandom));
        checks++;
        if (tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL tx_full: tx_ready=%b, required 0", tx_ready);
        end
        // Hold an offer against the full FIFO; it must not be taken yet.
        tx_data  = LS'($urandom);
        tx_valid = 1'b1;
        repeat (3) step();
        checks++;
        if (tx_ready !== 1'b0 || busy !== 1'b1 || n_starts - base !== 1) begin
            errors++;
            $display("FAIL tx_full_hold: tx_ready=%b busy=%b launches=%0d, required 0 1 1",
                     tx_ready, busy, n_starts - base);
        end
        resp_kick = 1'b1;
        resp_auto = 1'b1;
        push_word(tx_data);
        repeat (200) step();
        checks++;
        if (n_starts - base !== DEPTH || busy !== 1'b0 || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL rx_full_hold: launches=%0d busy=%b tx_ready=%b, required %0d 0 1",
                     n_starts - base, busy, tx_ready, DEPTH);
        end
        // Pop at RX full: the freed slot allows the launch on the same edge.
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        checks++;
        if (start_comm !== 1'b1) begin
            errors++;
            $display("FAIL pop_launch_same_cycle: start_comm=%b, required 1", start_comm);
        end
        drain();
        checks++;
        if (n_starts - base !== DEPTH + 2 || tx_ready !== 1'b1 || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_empty_total: launches=%0d tx_ready=%b rx_valid=%b, required %0d 1 0",
                     n_starts - base, tx_ready, rx_valid, DEPTH + 2);
        end
    endtask

`ifdef SPI_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        resp_auto = 1'b0;
        rx_ready  = 1'b0;
        push_word(8'h3C);
        n = 0;
        while (!start_comm && n < 20) begin
            step();
            n++;
        end
        repeat (TIMEOUT) step();
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: err=%b busy=%b, required 0 1", err, busy);
        end
        step();
        checks++;
        if (err !== 1'b1 || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_set: err=%b rx_valid=%b, required 1 0", err, rx_valid);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        repeat (GAP + 2) step();
        checks++;
        if (busy !== 1'b0 || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: busy=%b rx_valid=%b, required 0 0", busy, rx_valid);
        end
        resp_auto = 1'b1;
        push_word(8'h5A);
        drain();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%b, required 1", err);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b, required 0", err);
        end
    endtask
`endif

    task automatic test_reset_mid_wait();
        int n;
        int hold;
        resp_auto = 1'b0;
        rx_ready  = 1'b0;
`ifdef SPI_SCHED_TIMEOUT_EN
        hold = 20;
`else
        hold = 150;
`endif
        push_word(LS'($urandom));
        n = 0;
        while (!start_comm && n < 20) begin
            step();
            n++;
        end
        repeat (hold) step();
        checks++;
        if (busy !== 1'b1 || rx_valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL wait_hold: busy=%b rx_valid=%b err=%b, required 1 0 0", busy, rx_valid, err);
        end
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("reset_mid_wait");
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        step();
        resp_auto = 1'b1;
        resp_lat  = 0;
        push_word(8'hC3);
        drain();
        checks++;
        if (busy !== 1'b0 || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_txn: busy=%b rx_valid=%b, required 0 0", busy, rx_valid);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single_word();
        test_burst();
        test_backpressure();
        test_full_empty();
`ifdef SPI_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
